// File: rtl/led7seg_pkg.sv
// rtl/led7seg_pkg.sv - shared FSM encoding and segment constants for the 7-segment scanner
package led7seg_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD      = 3'd1;
   localparam logic [2:0] ST_SEND      = 3'd2;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam logic [2:0] ST_DWELL     = 3'd5;

   // Active-high {g,f,e,d,c,b,a}; listed from F down to 0 so HEX_SEG[n] is digit n.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/led7seg_scan_ctrl_if.sv
// rtl/led7seg_scan_ctrl_if.sv - en/RDY handshake towards the hc595 shift-register driver
interface led7seg_scan_ctrl_if;
   logic        drv_en;
   logic [15:0] drv_data;
   logic        drv_rdy;

   modport master (output drv_en, output drv_data, input drv_rdy);
   modport slave  (input drv_en, input drv_data, output drv_rdy);
endinterface

// File: rtl/led7seg_scan_ctrl_hex_to_7seg.sv
// rtl/led7seg_scan_ctrl_hex_to_7seg.sv - nibble + dp + blank to polarity-adjusted segment byte
module hex_to_7seg
   import led7seg_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   logic [7:0] seg_hi;

   always_comb begin
      seg_hi = blank_i ? SEG_OFF : {dp_i, HEX_SEG[nibble_i]};
      seg_o  = ACTIVE_LOW ? (seg_hi ^ 8'hFF) : seg_hi;
   end

endmodule

// File: rtl/led7seg_scan_ctrl.sv
// rtl/led7seg_scan_ctrl.sv - multiplexed 7-segment scanner feeding a 16-bit hc595 driver
module led7seg_scan_ctrl
   import led7seg_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int DWELL_CYCLES   = 100000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable_i,
   input  logic [4*N_DIGITS-1:0] digits_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   input  logic [N_DIGITS-1:0]   blank_i,
   led7seg_scan_ctrl_if.master   drv,
   output logic                  frame_done_o,
   output logic [2:0]            cur_digit_o
);

   localparam int CNT_W = $clog2(DWELL_CYCLES + 1);

   logic [2:0]            state_q, state_d;
   logic [2:0]            cur_q, cur_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  en_q, en_d;
   logic [15:0]           data_q, data_d;
   logic                  frame_q, frame_d;
   logic [4*N_DIGITS-1:0] dig_snap_q, dig_snap_d;
   logic [N_DIGITS-1:0]   dp_snap_q, dp_snap_d;
   logic [N_DIGITS-1:0]   blank_snap_q, blank_snap_d;

   logic [31:0] dig_pad;
   logic [7:0]  dp_pad, blank_pad;
   logic [7:0]  seg_byte, sel_byte;

   // Digit 0 reads the live inputs because its snapshot is written on the same edge.
   always_comb begin
      if (cur_q == 3'd0) begin
         dig_pad   = 32'(digits_i);
         dp_pad    = 8'(dp_i);
         blank_pad = 8'(blank_i);
      end else begin
         dig_pad   = 32'(dig_snap_q);
         dp_pad    = 8'(dp_snap_q);
         blank_pad = 8'(blank_snap_q);
      end
      sel_byte = (8'd1 << cur_q) ^ (DIG_ACTIVE_LOW ? 8'hFF : 8'h00);
   end

   hex_to_7seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex (
      .nibble_i (dig_pad[cur_q*4 +: 4]),
      .dp_i     (dp_pad[cur_q]),
      .blank_i  (blank_pad[cur_q]),
      .seg_o    (seg_byte)
   );

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      cnt_d        = cnt_q;
      en_d         = 1'b0;
      data_d       = data_q;
      frame_d      = 1'b0;
      dig_snap_d   = dig_snap_q;
      dp_snap_d    = dp_snap_q;
      blank_snap_d = blank_snap_q;

      case (state_q)
         ST_IDLE: begin
            if (enable_i) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (cur_q == 3'd0) begin
               dig_snap_d   = digits_i;
               dp_snap_d    = dp_i;
               blank_snap_d = blank_i;
            end
            data_d  = {seg_byte, sel_byte};
            en_d    = drv.drv_rdy;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            // drv_en is a registered one-cycle pulse; leave once it has been shown.
            if (en_q) state_d = ST_WAIT_BUSY;
            else      en_d    = drv.drv_rdy;
         end
         ST_WAIT_BUSY: begin
            if (!drv.drv_rdy) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (drv.drv_rdy) begin
               cnt_d   = '0;
               state_d = ST_DWELL;
            end
         end
         ST_DWELL: begin
            if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
               if (cur_q == 3'(N_DIGITS - 1)) begin
                  frame_d = 1'b1;
                  cur_d   = 3'd0;
               end else begin
                  cur_d = cur_q + 3'd1;
               end
               state_d = enable_i ? ST_LOAD : ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cur_q        <= 3'd0;
         cnt_q        <= '0;
         en_q         <= 1'b0;
         data_q       <= 16'h0000;
         frame_q      <= 1'b0;
         dig_snap_q   <= '0;
         dp_snap_q    <= '0;
         blank_snap_q <= '0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         cnt_q        <= cnt_d;
         en_q         <= en_d;
         data_q       <= data_d;
         frame_q      <= frame_d;
         dig_snap_q   <= dig_snap_d;
         dp_snap_q    <= dp_snap_d;
         blank_snap_q <= blank_snap_d;
      end
   end

   assign drv.drv_en   = en_q;
   assign drv.drv_data = data_q;
   assign frame_done_o = frame_q;
   assign cur_digit_o  = cur_q;

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// tb/tb_led7seg_scan_ctrl.sv - scoreboard bench for led7seg_scan_ctrl
`timescale 1ns/1ps
module tb_led7seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] digits;
   logic [3:0]  dp, blank;
   logic        frame_done;
   logic [2:0]  cur_digit;
   logic        stall;
   logic        rdy_q;
   int          busy;

   int total = 0;
   int bad   = 0;

   // bit 16 set marks an expected frame_done pulse, otherwise an expected drv_data word
   logic [16:0] sb[$];
   logic        prev_en = 1'b0;

   led7seg_scan_ctrl_if bus();

   led7seg_scan_ctrl #(
      .N_DIGITS(4), .DWELL_CYCLES(10), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .digits_i(digits),
      .dp_i(dp), .blank_i(blank), .drv(bus.master),
      .frame_done_o(frame_done), .cur_digit_o(cur_digit)
   );

   always #5 clk = ~clk;

   // hc595 driver stand-in: RDY drops for 5 cycles after accepting en
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b1;
         busy  <= 0;
      end else if (rdy_q && bus.drv_en) begin
         rdy_q <= 1'b0;
         busy  <= 5;
      end else if (!rdy_q) begin
         if (busy == 1) rdy_q <= 1'b1;
         busy <= busy - 1;
      end
   end
   assign bus.drv_rdy = rdy_q & ~stall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.drv_en) begin
            check("en_with_rdy", {31'd0, bus.drv_rdy}, 32'd1);
            check("en_single", {31'd0, prev_en}, 32'd0);
            check("sb_has_word", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) check("word", {15'd0, 1'b0, bus.drv_data}, 32'(sb.pop_front()));
         end
         if (frame_done) begin
            check("sb_has_frame", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) check("frame_done_order", 32'(sb.pop_front()), 32'h10000);
         end
      end
      prev_en = bus.drv_en;
   end

   task automatic push_words(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
      sb.push_back({1'b0, w0});
      sb.push_back({1'b0, w1});
      sb.push_back({1'b0, w2});
      sb.push_back({1'b0, w3});
      sb.push_back(17'h10000);
   endtask

   task automatic wait_digit(input logic [2:0] d, input int budget, input string name);
      int n = 0;
      while (cur_digit !== d && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {29'd0, cur_digit}, {29'd0, d});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_en"},    {31'd0, bus.drv_en}, 32'd0);
      check({tag, "_data"},  {16'd0, bus.drv_data}, 32'd0);
      check({tag, "_frame"}, {31'd0, frame_done}, 32'd0);
      check({tag, "_cur"},   {29'd0, cur_digit}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int en_bad;
      int data_bad;
      rst_n = 1'b0; enable = 1'b0; stall = 1'b0;
      digits = 16'h4321; dp = 4'b0000; blank = 4'b0000;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // frame 1: plain 4321, then inputs change mid-frame to 8765
      push_words(16'hF901, 16'hA402, 16'hB004, 16'h9908);
      rst_n = 1'b1; enable = 1'b1;
      wait_digit(3'd2, 300, "f1_reach_d2");
      digits = 16'h8765;
      push_words(16'h9201, 16'h8202, 16'hF804, 16'h8008);
      wait_digit(3'd0, 300, "f2_reach_d0");
      wait_digit(3'd1, 300, "f2_reach_d1");
      digits = 16'h4321; blank = 4'b0100; dp = 4'b0001;
      sb.push_back({1'b0, 16'h7901});
      sb.push_back({1'b0, 16'hA402});
      sb.push_back({1'b0, 16'hFF04});

      // frame 3: stall RDY while digit 2 sits in SEND
      wait_digit(3'd0, 300, "f3_reach_d0");
      wait_digit(3'd1, 300, "f3_reach_d1");
      repeat (12) @(negedge clk);
      stall = 1'b1;
      wait_digit(3'd2, 300, "f3_reach_d2");
      repeat (3) @(negedge clk);
      en_bad = 0; data_bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.drv_en !== 1'b0) en_bad++;
         if (bus.drv_data !== 16'hFF04) data_bad++;
      end
      check("stall_no_en", en_bad, 0);
      check("stall_data_stable", data_bad, 0);
      stall = 1'b0;
      @(posedge clk); #1;
      check("en_after_rdy", {31'd0, bus.drv_en}, 32'd1);
      @(posedge clk); #1;
      check("en_one_cycle", {31'd0, bus.drv_en}, 32'd0);

      // drop enable while the driver is busy: transfer and dwell still finish
      enable = 1'b0;
      repeat (80) @(negedge clk);
      check("idle_cur", {29'd0, cur_digit}, 32'd3);
      check("idle_sb_empty", sb.size(), 0);

      sb.push_back({1'b0, 16'h9908});
      sb.push_back(17'h10000);
      sb.push_back({1'b0, 16'h7901});
      enable = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("resume_drained", sb.size(), 0);

      // reset in the middle of digit 0's dwell
      repeat (10) @(negedge clk);
      check("pre_rst_data", {16'd0, bus.drv_data}, 32'h7901);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      sb.push_back({1'b0, 16'h7901});
      rst_n = 1'b1;
      n = 0;
      while (bus.drv_en !== 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_first_en_le2", {31'd0, n <= 2}, 32'd1);
      enable = 1'b0;
      repeat (60) @(negedge clk);
      check("final_cur", {29'd0, cur_digit}, 32'd1);
      check("final_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
